// File: rtl/video_pkg.sv
// Shared raster timing constants, framebuffer defaults and address helper for the
// 512x342 video fetch/shift path.
`timescale 1ns/1ps
package video_pkg;

  localparam int H_W    = 6;
  localparam int V_W    = 9;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;

  localparam logic [H_W-1:0] H_WORDS_TOTAL = 6'd44;
  localparam logic [H_W-1:0] ACTIVE_WORDS  = 6'd32;
  localparam logic [H_W-1:0] HSYNC_START   = 6'd34;
  localparam logic [H_W-1:0] HSYNC_END     = 6'd42;

  localparam logic [V_W-1:0] V_LINES_TOTAL = 9'd370;
  localparam logic [V_W-1:0] ACTIVE_LINES  = 9'd342;
  localparam logic [V_W-1:0] VSYNC_START   = 9'd345;
  localparam logic [V_W-1:0] VSYNC_END     = 9'd349;

  localparam logic [ADDR_W-1:0] SCREEN_BASE = 21'h1F2C80;
  localparam logic [ADDR_W-1:0] ALT_OFFSET  = 21'h004000;

  typedef struct packed {
    logic de;
    logic hblank;
    logic vblank;
    logic hsync_n;
    logic vsync_n;
  } raster_t;

  localparam raster_t RASTER_RESET = '{de: 1'b0, hblank: 1'b1, vblank: 1'b0,
                                       hsync_n: 1'b1, vsync_n: 1'b1};

  // Each line is 32 words, so the line offset is a plain shift; wraps modulo 2^21.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [V_W-1:0]    line,
                                                  input logic [4:0]        word);
    logic [ADDR_W-1:0] line_off;
    logic [ADDR_W-1:0] word_off;
    line_off = {{(ADDR_W-V_W-5){1'b0}}, line, 5'b00000};
    word_off = {{(ADDR_W-5){1'b0}}, word};
    return base + line_off + word_off;
  endfunction

endpackage

// File: rtl/video_fetch_shifter_if.sv
// Memory-side bus between the video fetcher (master) and the RAM/bus-phase logic (slave).
`timescale 1ns/1ps
interface video_fetch_shifter_if import video_pkg::*; ();

  logic              cycle_ready;
  logic              video_bus_control;
  logic [DATA_W-1:0] vid_data;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_req;

  modport master (
    input  cycle_ready,
    input  video_bus_control,
    input  vid_data,
    output vid_addr,
    output vid_req
  );

  modport slave (
    output cycle_ready,
    output video_bus_control,
    output vid_data,
    input  vid_addr,
    input  vid_req
  );

endinterface

// File: rtl/video_raster_counter.sv
// Word/line counters advanced only by fetch events, with active/blank/sync decode
// of the word currently being addressed.
`timescale 1ns/1ps
module video_raster_counter
  import video_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           fetch,
  output logic [4:0]     h_word,
  output logic [V_W-1:0] v_cnt,
  output raster_t        dec,
  output logic           vs_start_stb
);

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           h_wrap;
  logic           v_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_WORDS_TOTAL - 6'd1);
    v_wrap  = (v_cnt_q == V_LINES_TOTAL - 9'd1);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (fetch) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 9'd1;
      end else begin
        h_cnt_d = h_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    dec.hblank  = (h_cnt_q >= ACTIVE_WORDS);
    dec.vblank  = (v_cnt_q >= ACTIVE_LINES);
    dec.de      = !dec.hblank && !dec.vblank;
    dec.hsync_n = !((h_cnt_q >= HSYNC_START) && (h_cnt_q < HSYNC_END));
    dec.vsync_n = !((v_cnt_q >= VSYNC_START) && (v_cnt_q < VSYNC_END));
  end

  // Fires on the fetch that moves the line counter onto the first vsync line.
  assign vs_start_stb = fetch && h_wrap && (v_cnt_q == VSYNC_START - 9'd1);
  assign h_word       = h_cnt_q[4:0];
  assign v_cnt        = v_cnt_q;

endmodule

// File: rtl/video_fetch_shifter.sv
// Framebuffer fetch, 16-bit pixel serialiser and aligned raster timing outputs.
// Optional alternate-buffer select is built when VIDEO_ALT_BUFFER_EN is defined.
`timescale 1ns/1ps
module video_fetch_shifter
  import video_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  video_fetch_shifter_if.master bus,
`ifdef VIDEO_ALT_BUFFER_EN
  input  logic                  alt_screen,
`endif
  output logic                  pixel,
  output logic                  de,
  output logic                  hblank,
  output logic                  vblank,
  output logic                  hsync_n,
  output logic                  vsync_n
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  // Assertion is asynchronous; release is retimed to clk through two flops.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  logic           fetch;
  logic [4:0]     h_word;
  logic [V_W-1:0] v_cnt;
  raster_t        dec;
  logic           vs_start_stb;

  assign fetch = bus.cycle_ready && bus.video_bus_control;

  video_raster_counter u_raster (
    .clk          (clk),
    .reset_n      (rst_n_int),
    .fetch        (fetch),
    .h_word       (h_word),
    .v_cnt        (v_cnt),
    .dec          (dec),
    .vs_start_stb (vs_start_stb)
  );

  logic [ADDR_W-1:0] base;

`ifdef VIDEO_ALT_BUFFER_EN
  logic alt_q, alt_d;

  // Latched once per frame so a mid-frame toggle only takes effect next frame.
  always_comb begin
    alt_d = alt_q;
    if (vs_start_stb) alt_d = alt_screen;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) alt_q <= 1'b0;
    else            alt_q <= alt_d;
  end

  assign base = alt_q ? (SCREEN_BASE - ALT_OFFSET) : SCREEN_BASE;
`else
  logic unused_vs_start_stb;
  assign unused_vs_start_stb = vs_start_stb;
  assign base = SCREEN_BASE;
`endif

  assign bus.vid_addr = word_addr(base, v_cnt, h_word);
  assign bus.vid_req  = dec.de;

  logic [DATA_W-1:0] sr_q, sr_d;
  logic              pixel_q, pixel_d;
  raster_t           dec_q, dec_d;
  raster_t           out_q, out_d;
  logic              load_q, load_d;

  // Blank words load zeros, so pixel is forced low wherever de is low.
  always_comb begin
    sr_d    = {sr_q[DATA_W-2:0], 1'b0};
    dec_d   = dec_q;
    load_d  = fetch;
    pixel_d = sr_q[DATA_W-1];
    if (fetch) begin
      sr_d  = dec.de ? bus.vid_data : '0;
      dec_d = dec;
    end
  end

  // Timing outputs take the loaded word's decode one clk after the fetch,
  // the same edge on which its MSB reaches pixel.
  always_comb begin
    out_d = out_q;
    if (load_q) out_d = dec_q;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sr_q    <= '0;
      pixel_q <= 1'b0;
      dec_q   <= RASTER_RESET;
      out_q   <= RASTER_RESET;
      load_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      pixel_q <= pixel_d;
      dec_q   <= dec_d;
      out_q   <= out_d;
      load_q  <= load_d;
    end
  end

  assign pixel   = pixel_q;
  assign de      = out_q.de;
  assign hblank  = out_q.hblank;
  assign vblank  = out_q.vblank;
  assign hsync_n = out_q.hsync_n;
  assign vsync_n = out_q.vsync_n;

endmodule

// File: tb/tb_video_fetch_shifter.sv
// Directed bench for video_fetch_shifter: fetch/serialise, raster timing, wraps,
// mid-line reset and (with VIDEO_ALT_BUFFER_EN) frame-latched buffer select.
`timescale 1ns/1ps
module tb_video_fetch_shifter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alt_screen;
  logic       pixel, de, hblank, vblank, hsync_n, vsync_n;
  logic [3:0] phase;
  int         checks = 0;
  int         errors = 0;
  int         n_low;
  int         first_low;

  video_fetch_shifter_if bus_if ();

  video_fetch_shifter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if.master),
`ifdef VIDEO_ALT_BUFFER_EN
    .alt_screen (alt_screen),
`endif
    .pixel      (pixel),
    .de         (de),
    .hblank     (hblank),
    .vblank     (vblank),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Normal bus phasing: cycle_ready every 8 clk, video owns every other slot.
  task automatic tick(input logic [15:0] d);
    bus_if.cycle_ready       = (phase[2:0] == 3'd7);
    bus_if.video_bus_control = phase[3];
    bus_if.vid_data          = d;
    @(posedge clk);
    #1;
    phase = phase + 4'd1;
  endtask

  task automatic idle();
    bus_if.cycle_ready       = 1'b0;
    bus_if.video_bus_control = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [15:0] d);
    repeat (16) tick(d);
  endtask

  // Malformed stimulus: a fetch event on every clk.
  task automatic fast(input int n, input logic [15:0] d);
    repeat (n) begin
      bus_if.cycle_ready       = 1'b1;
      bus_if.video_bus_control = 1'b1;
      bus_if.vid_data          = d;
      @(posedge clk);
      #1;
    end
    bus_if.cycle_ready       = 1'b0;
    bus_if.video_bus_control = 1'b0;
  endtask

  initial begin
    phase                    = 4'd0;
    reset_n                  = 1'b0;
    alt_screen               = 1'b0;
    bus_if.cycle_ready       = 1'b0;
    bus_if.video_bus_control = 1'b0;
    bus_if.vid_data          = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixel", pixel, 0);
    chk("rst_de", de, 0);
    chk("rst_hblank", hblank, 1);
    chk("rst_vblank", vblank, 0);
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_addr", bus_if.vid_addr, 32'h1F2C80);
    chk("rst_req", bus_if.vid_req, 1);

    reset_n = 1'b1;
    repeat (3) idle();
    phase = 4'd0;
    repeat (15) tick(16'h0000);
    chk("addr_before_f1", bus_if.vid_addr, 32'h1F2C80);
    tick(16'h8001);
    chk("addr_after_f1", bus_if.vid_addr, 32'h1F2C81);

    for (int k = 1; k <= 16; k++) begin
      tick(16'h0000);
      chk($sformatf("pix8001_k%0d", k), pixel, (k == 1 || k == 16) ? 1 : 0);
      chk($sformatf("de_w0_k%0d", k), de, 1);
    end

    repeat (30) slot(16'hFFFF);
    chk("req_h32", bus_if.vid_req, 0);
    chk("addr_h32", bus_if.vid_addr, 32'h1F2C80);
    chk("de_w30", de, 1);
    chk("pixel_w30", pixel, 1);
    slot(16'hFFFF);
    tick(16'hFFFF);
    chk("pixel_w32", pixel, 0);
    chk("de_w32", de, 0);
    chk("hblank_w32", hblank, 1);
    chk("vblank_w32", vblank, 0);
    repeat (15) tick(16'hFFFF);

    n_low = 0;
    first_low = 0;
    for (int t = 1; t <= 176; t++) begin
      tick(16'h0000);
      if (!hsync_n) begin
        n_low++;
        if (first_low == 0) first_low = t;
      end
      if (t == 160) chk("addr_l1_w0", bus_if.vid_addr, 32'h1F2CA0);
    end
    chk("hsync_low_clks", n_low, 128);
    chk("hsync_first", first_low, 17);
    chk("addr_l1_w1", bus_if.vid_addr, 32'h1F2CA1);

    fast(15003, 16'h0000);
    chk("vblank_l341", vblank, 0);
    chk("req_l342", bus_if.vid_req, 0);
    chk("addr_l342", bus_if.vid_addr, 32'h1F5740);
    fast(2, 16'h0000);
    chk("vblank_l342", vblank, 1);
    chk("de_l342", de, 0);
    chk("vsync_n_l342", vsync_n, 1);
    fast(86, 16'h0000);

    phase = 4'd0;
    n_low = 0;
    first_low = 0;
    for (int t = 1; t <= 4224; t++) begin
      tick(16'h0000);
      if (!vsync_n) begin
        n_low++;
        if (first_low == 0) first_low = t;
      end
    end
    chk("vsync_low_clks", n_low, 2816);
    chk("vsync_first", first_low, 721);
    chk("vblank_l349", vblank, 1);

    fast(879, 16'h0000);
    chk("addr_l369_w43", bus_if.vid_addr, 32'h1F5AAB);
    chk("req_l369", bus_if.vid_req, 0);
    chk("vblank_l369", vblank, 1);
    fast(1, 16'h0000);
    chk("addr_wrap", bus_if.vid_addr, 32'h1F2C80);
    chk("req_wrap", bus_if.vid_req, 1);
    fast(2, 16'hFFFF);
    chk("vblank_f2", vblank, 0);
    chk("de_f2", de, 1);
    chk("hblank_f2", hblank, 0);
    fast(15, 16'hFFFF);
    chk("pixel_pre_rst", pixel, 1);
    chk("de_pre_rst", de, 1);

    #2 reset_n = 1'b0;
    #1;
    chk("arst_pixel", pixel, 0);
    chk("arst_de", de, 0);
    chk("arst_hblank", hblank, 1);
    chk("arst_vblank", vblank, 0);
    chk("arst_hsync_n", hsync_n, 1);
    chk("arst_vsync_n", vsync_n, 1);
    chk("arst_addr", bus_if.vid_addr, 32'h1F2C80);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) idle();
    phase = 4'd0;
    repeat (15) tick(16'h0000);
    chk("addr_restart", bus_if.vid_addr, 32'h1F2C80);
    tick(16'h0000);
    chk("addr_restart_f1", bus_if.vid_addr, 32'h1F2C81);

`ifdef VIDEO_ALT_BUFFER_EN
    alt_screen = 1'b1;
    fast(43, 16'h0000);
    chk("alt_same_frame", bus_if.vid_addr, 32'h1F2CA0);
    fast(15180, 16'h0000);
    alt_screen = 1'b0;
    fast(1056, 16'h0000);
    chk("alt_next_frame", bus_if.vid_addr, 32'h1EEC80);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
